// File: rtl/roce_stack_addr_lookup_if.sv
// roce_stack_addr_lookup_if: lookup request / translation response handshake bundle
interface roce_stack_addr_lookup_if;
    typedef struct packed {
        logic [63:0] paddr;
        logic [47:0] buflen;
        logic [3:0]  accesdesc;
    } dma_req_t;

    logic        req_addr_valid_i;
    logic        req_addr_ready_o;
    logic [63:0] req_addr_vaddr_i;
    logic [15:0] req_addr_qpn_i;
    logic        resp_addr_valid_o;
    logic        resp_addr_ready_i;
    dma_req_t    resp_addr_data_o;

    modport master (
        output req_addr_valid_i, req_addr_vaddr_i, req_addr_qpn_i, resp_addr_ready_i,
        input  req_addr_ready_o, resp_addr_valid_o, resp_addr_data_o
    );

    modport slave (
        input  req_addr_valid_i, req_addr_vaddr_i, req_addr_qpn_i, resp_addr_ready_i,
        output req_addr_ready_o, resp_addr_valid_o, resp_addr_data_o
    );
endinterface

// File: rtl/roce_stack_addr_lookup.sv
// roce_stack_addr_lookup: per-QP virtual-to-physical translation table with a 3-state lookup FSM
module roce_stack_addr_lookup #(
    parameter  int NUM_ENTRIES = 16,
    localparam int IW          = $clog2(NUM_ENTRIES)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    roce_stack_addr_lookup_if.slave bus,
    input  logic          cfg_wr_valid_i,
    input  logic [IW-1:0] cfg_wr_idx_i,
    input  logic          cfg_wr_entry_valid_i,
    input  logic [15:0]   cfg_wr_qpn_i,
    input  logic [63:0]   cfg_wr_vbase_i,
    input  logic [63:0]   cfg_wr_pbase_i,
    input  logic [47:0]   cfg_wr_len_i,
    input  logic [3:0]    cfg_wr_access_i,
    output logic [31:0]   miss_cnt_o
);
    typedef enum logic [1:0] {LK_IDLE, LK_MATCH, LK_RESP} state_t;

    state_t state, state_nxt;

    logic [NUM_ENTRIES-1:0] ent_valid;
    logic [15:0]            ent_qpn    [NUM_ENTRIES];
    logic [63:0]            ent_vbase  [NUM_ENTRIES];
    logic [63:0]            ent_pbase  [NUM_ENTRIES];
    logic [47:0]            ent_len    [NUM_ENTRIES];
    logic [3:0]             ent_access [NUM_ENTRIES];

    logic [63:0]            req_vaddr;
    logic [15:0]            req_qpn;
    logic [NUM_ENTRIES-1:0] hit;
    logic [63:0]            off [NUM_ENTRIES];
    logic [IW-1:0]          sel;
    logic [115:0]           resp_nxt;
    logic                   wr_en;
    logic                   accept;

    // Table writes only land while idle, so a lookup never sees a half-updated entry.
    assign wr_en  = state == LK_IDLE && cfg_wr_valid_i;
    assign accept = bus.req_addr_valid_i && bus.req_addr_ready_o;

    assign bus.req_addr_ready_o  = state == LK_IDLE && !cfg_wr_valid_i;
    assign bus.resp_addr_valid_o = state == LK_RESP;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
        assign off[i] = req_vaddr - ent_vbase[i];
        assign hit[i] = ent_valid[i] && ent_qpn[i] == req_qpn &&
                        req_vaddr >= ent_vbase[i] && off[i] < {16'h0, ent_len[i]};
    end

    // Priority select: scan downward so the lowest hitting index wins.
    always_comb begin
        sel = '0;
        for (int k = NUM_ENTRIES - 1; k >= 0; k--)
            if (hit[k]) sel = IW'(k);
    end

    assign resp_nxt = |hit ? {ent_pbase[sel] + off[sel], ent_len[sel] - off[sel][47:0], ent_access[sel]} : '0;

    // Next-state logic: idle -> match on accept, match -> resp, resp -> idle on consumer ready.
    always_comb begin
        state_nxt = state;
        case (state)
            LK_IDLE:  state_nxt = accept ? LK_MATCH : LK_IDLE;
            LK_MATCH: state_nxt = LK_RESP;
            LK_RESP:  state_nxt = bus.resp_addr_ready_i ? LK_IDLE : LK_RESP;
            default:  state_nxt = LK_IDLE;
        endcase
    end

    // State, request capture, response register and saturating miss counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                <= LK_IDLE;
            req_vaddr            <= '0;
            req_qpn              <= '0;
            bus.resp_addr_data_o <= '0;
            miss_cnt_o           <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_vaddr <= bus.req_addr_vaddr_i;
                req_qpn   <= bus.req_addr_qpn_i;
            end
            if (state == LK_MATCH) begin
                bus.resp_addr_data_o <= resp_nxt;
                if (!(|hit) && miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end

    // Entry valid bits are the only table state cleared by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ent_valid <= '0;
        else if (wr_en) ent_valid[cfg_wr_idx_i] <= cfg_wr_entry_valid_i;
    end

    // Entry payload fields; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            ent_qpn[cfg_wr_idx_i]    <= cfg_wr_qpn_i;
            ent_vbase[cfg_wr_idx_i]  <= cfg_wr_vbase_i;
            ent_pbase[cfg_wr_idx_i]  <= cfg_wr_pbase_i;
            ent_len[cfg_wr_idx_i]    <= cfg_wr_len_i;
            ent_access[cfg_wr_idx_i] <= cfg_wr_access_i;
        end
    end
endmodule

// File: tb/tb_roce_stack_addr_lookup.sv
// tb_roce_stack_addr_lookup: directed table-driven bench for the address lookup block
module tb_roce_stack_addr_lookup;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_wr_valid_i = 1'b0;
    logic [3:0]  cfg_wr_idx_i = '0;
    logic        cfg_wr_entry_valid_i = 1'b0;
    logic [15:0] cfg_wr_qpn_i = '0;
    logic [63:0] cfg_wr_vbase_i = '0;
    logic [63:0] cfg_wr_pbase_i = '0;
    logic [47:0] cfg_wr_len_i = '0;
    logic [3:0]  cfg_wr_access_i = '0;
    logic [31:0] miss_cnt_o;

    int checks = 0;
    int errors = 0;

    roce_stack_addr_lookup_if bus ();

    roce_stack_addr_lookup #(.NUM_ENTRIES(16)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .bus                  (bus),
        .cfg_wr_valid_i       (cfg_wr_valid_i),
        .cfg_wr_idx_i         (cfg_wr_idx_i),
        .cfg_wr_entry_valid_i (cfg_wr_entry_valid_i),
        .cfg_wr_qpn_i         (cfg_wr_qpn_i),
        .cfg_wr_vbase_i       (cfg_wr_vbase_i),
        .cfg_wr_pbase_i       (cfg_wr_pbase_i),
        .cfg_wr_len_i         (cfg_wr_len_i),
        .cfg_wr_access_i      (cfg_wr_access_i),
        .miss_cnt_o           (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] qpn;
        logic [63:0] vaddr;
        logic [63:0] paddr;
        logic [47:0] buflen;
        logic [3:0]  acc;
        logic [31:0] miss;
    } vec_t;

    vec_t vt [10];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic v, input logic [15:0] q,
                             input logic [63:0] vb, input logic [63:0] pb,
                             input logic [47:0] len, input logic [3:0] acc);
        cfg_wr_valid_i = 1'b1;
        cfg_wr_idx_i = idx;
        cfg_wr_entry_valid_i = v;
        cfg_wr_qpn_i = q;
        cfg_wr_vbase_i = vb;
        cfg_wr_pbase_i = pb;
        cfg_wr_len_i = len;
        cfg_wr_access_i = acc;
        tick();
        cfg_wr_valid_i = 1'b0;
    endtask

    task automatic lookup(input string name, input logic [15:0] q, input logic [63:0] va,
                          output logic [63:0] pa, output logic [47:0] bl, output logic [3:0] ac);
        bus.req_addr_valid_i = 1'b1;
        bus.req_addr_qpn_i = q;
        bus.req_addr_vaddr_i = va;
        #1;
        chk({name, " req_ready"}, 128'(bus.req_addr_ready_o), 128'd1);
        tick();
        bus.req_addr_valid_i = 1'b0;
        chk({name, " valid_early"}, 128'(bus.resp_addr_valid_o), 128'd0);
        tick();
        chk({name, " valid_lat2"}, 128'(bus.resp_addr_valid_o), 128'd1);
        pa = bus.resp_addr_data_o.paddr;
        bl = bus.resp_addr_data_o.buflen;
        ac = bus.resp_addr_data_o.accesdesc;
        bus.resp_addr_ready_i = 1'b1;
        tick();
        bus.resp_addr_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] pa;
        logic [47:0] bl;
        logic [3:0]  ac;

        vt[0] = '{16'd5, 64'h1010, 64'h8000_0010, 48'hF0, 4'h3, 32'd0};
        vt[1] = '{16'd5, 64'h1100, 64'h0, 48'h0, 4'h0, 32'd1};
        vt[2] = '{16'd6, 64'h1010, 64'h0, 48'h0, 4'h0, 32'd2};
        vt[3] = '{16'd5, 64'h1000, 64'h8000_0000, 48'h100, 4'h3, 32'd2};
        vt[4] = '{16'd5, 64'h10FF, 64'h8000_00FF, 48'h1, 4'h3, 32'd2};
        vt[5] = '{16'd5, 64'h0FFF, 64'h0, 48'h0, 4'h0, 32'd3};
        vt[6] = '{16'd9, 64'h2010, 64'h10_0010, 48'h70, 4'hA, 32'd3};
        vt[7] = '{16'd9, 64'h2090, 64'h20_0090, 48'hF70, 4'h5, 32'd3};
        vt[8] = '{16'd2, 64'h30, 64'h10, 48'h20, 4'hF, 32'd3};
        vt[9] = '{16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_3FFF, 48'hFFFF_FFFF_0000, 4'hC, 32'd3};

        bus.req_addr_valid_i = 1'b0;
        bus.req_addr_vaddr_i = '0;
        bus.req_addr_qpn_i = '0;
        bus.resp_addr_ready_i = 1'b0;

        #1;
        chk("rst resp_valid", 128'(bus.resp_addr_valid_o), 128'd0);
        chk("rst resp_data", 128'(bus.resp_addr_data_o), 128'd0);
        chk("rst miss_cnt", 128'(miss_cnt_o), 128'd0);
        chk("rst req_ready", 128'(bus.req_addr_ready_o), 128'd1);
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        cfg_write(4'd3, 1'b1, 16'd5, 64'h1000, 64'h8000_0000, 48'h100, 4'h3);
        cfg_write(4'd1, 1'b1, 16'd9, 64'h2000, 64'h10_0000, 48'h80, 4'hA);
        cfg_write(4'd7, 1'b1, 16'd9, 64'h2000, 64'h20_0000, 48'h1000, 4'h5);
        cfg_write(4'd0, 1'b1, 16'd2, 64'h10, 64'hFFFF_FFFF_FFFF_FFF0, 48'h40, 4'hF);
        cfg_write(4'd15, 1'b1, 16'hFFFF, 64'hFFFF_FFFF_FFFF_0000, 64'h4000, 48'hFFFF_FFFF_FFFF, 4'hC);

        for (int i = 0; i < 10; i++) begin
            lookup($sformatf("vec%0d", i), vt[i].qpn, vt[i].vaddr, pa, bl, ac);
            chk($sformatf("vec%0d paddr", i), 128'(pa), 128'(vt[i].paddr));
            chk($sformatf("vec%0d buflen", i), 128'(bl), 128'(vt[i].buflen));
            chk($sformatf("vec%0d acc", i), 128'(ac), 128'(vt[i].acc));
            chk($sformatf("vec%0d miss_cnt", i), 128'(miss_cnt_o), 128'(vt[i].miss));
        end

        // Backpressure: response held for 5 cycles while a new request waits; a
        // config write attempted during the response must be ignored.
        bus.req_addr_valid_i = 1'b1;
        bus.req_addr_qpn_i = 16'd5;
        bus.req_addr_vaddr_i = 64'h1010;
        tick();
        bus.req_addr_vaddr_i = 64'h1020;
        tick();
        cfg_write(4'd3, 1'b0, 16'd0, 64'h0, 64'h0, 48'h0, 4'h0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d valid", c), 128'(bus.resp_addr_valid_o), 128'd1);
            chk($sformatf("bp%0d data", c), 128'(bus.resp_addr_data_o), {12'h0, 64'h8000_0010, 48'hF0, 4'h3});
            chk($sformatf("bp%0d req_ready", c), 128'(bus.req_addr_ready_o), 128'd0);
            if (c < 4) tick();
        end
        bus.resp_addr_ready_i = 1'b1;
        tick();
        bus.resp_addr_ready_i = 1'b0;
        chk("bp after_hs valid", 128'(bus.resp_addr_valid_o), 128'd0);
        chk("bp after_hs req_ready", 128'(bus.req_addr_ready_o), 128'd1);
        tick();
        bus.req_addr_valid_i = 1'b0;
        chk("bp2 valid_early", 128'(bus.resp_addr_valid_o), 128'd0);
        tick();
        chk("bp2 valid", 128'(bus.resp_addr_valid_o), 128'd1);
        chk("bp2 data", 128'(bus.resp_addr_data_o), {12'h0, 64'h8000_0020, 48'hE0, 4'h3});
        bus.resp_addr_ready_i = 1'b1;
        tick();
        bus.resp_addr_ready_i = 1'b0;

        // Simultaneous write and request: write wins, request lands next cycle and sees it.
        bus.req_addr_valid_i = 1'b1;
        bus.req_addr_qpn_i = 16'h33;
        bus.req_addr_vaddr_i = 64'h5004;
        cfg_wr_valid_i = 1'b1;
        cfg_wr_idx_i = 4'd4;
        cfg_wr_entry_valid_i = 1'b1;
        cfg_wr_qpn_i = 16'h33;
        cfg_wr_vbase_i = 64'h5000;
        cfg_wr_pbase_i = 64'h9000;
        cfg_wr_len_i = 48'h10;
        cfg_wr_access_i = 4'h6;
        #1;
        chk("wr_req ready_blocked", 128'(bus.req_addr_ready_o), 128'd0);
        tick();
        cfg_wr_valid_i = 1'b0;
        lookup("wr_req", 16'h33, 64'h5004, pa, bl, ac);
        chk("wr_req paddr", 128'(pa), 128'h9004);
        chk("wr_req buflen", 128'(bl), 128'hC);
        chk("wr_req acc", 128'(ac), 128'h6);

        cfg_write(4'd4, 1'b0, 16'h33, 64'h5000, 64'h9000, 48'h10, 4'h6);
        lookup("inval", 16'h33, 64'h5004, pa, bl, ac);
        chk("inval paddr", 128'(pa), 128'h0);
        chk("inval buflen", 128'(bl), 128'h0);
        chk("inval miss_cnt", 128'(miss_cnt_o), 128'd4);

        // Reset while the lookup sits in the match state.
        bus.req_addr_valid_i = 1'b1;
        bus.req_addr_qpn_i = 16'd5;
        bus.req_addr_vaddr_i = 64'h1010;
        tick();
        bus.req_addr_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("midrst valid", 128'(bus.resp_addr_valid_o), 128'd0);
        chk("midrst miss_cnt", 128'(miss_cnt_o), 128'd0);
        chk("midrst data", 128'(bus.resp_addr_data_o), 128'd0);
        chk("midrst req_ready", 128'(bus.req_addr_ready_o), 128'd1);
        tick();
        rst_i = 1'b0;
        tick();
        chk("postrst valid", 128'(bus.resp_addr_valid_o), 128'd0);
        tick();
        chk("postrst valid2", 128'(bus.resp_addr_valid_o), 128'd0);
        lookup("postrst", 16'd5, 64'h1010, pa, bl, ac);
        chk("postrst paddr", 128'(pa), 128'h0);
        chk("postrst buflen", 128'(bl), 128'h0);
        chk("postrst miss_cnt", 128'(miss_cnt_o), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/roce_stack_addr_lookup.md
ROCE_STACK_ADDR_LOOKUP -- requirements
Module: roce_stack_addr_lookup

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16, number of translation entries (power of two, 2..64).
REQ-002 SHALL have clock/reset: one clock and an asynchronous, active-high reset; ports clk_i and rst_i, listed first.
REQ-003 clk_i  in  1  clock.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 req_addr_valid_i  in  1  lookup request valid.
REQ-006 req_addr_ready_o  out  1  lookup request accepted.
REQ-007 req_addr_vaddr_i  in  64  virtual address to translate.
REQ-008 req_addr_qpn_i  in  16  queue pair number.
REQ-009 resp_addr_valid_o  out  1  translation result valid.
REQ-010 resp_addr_ready_i  in  1  consumer accepts result.
REQ-011 resp_addr_data_o  out  dma_req_t  {paddr[63:0], buflen[47:0], accesdesc[3:0]}.
REQ-012 cfg_wr_valid_i  in  1  table write strobe, single cycle.
REQ-013 cfg_wr_idx_i  in  log2(NUM_ENTRIES)  entry index.
REQ-014 cfg_wr_entry_valid_i  in  1  0 = invalidate entry.
REQ-015 cfg_wr_qpn_i / cfg_wr_vbase_i / cfg_wr_pbase_i / cfg_wr_len_i / cfg_wr_access_i  in  16/64/64/48/4  entry fields.
REQ-016 miss_cnt_o  out  32  number of missed lookups.

Function
REQ-017 FSM states SHALL be LK_IDLE, LK_MATCH, LK_RESP.
REQ-018 req_addr_ready_o SHALL equal (state==LK_IDLE) && !cfg_wr_valid_i; request accepted on valid&&ready, vaddr/qpn registered, state -> LK_MATCH.
REQ-019 Config writes SHALL be applied only in LK_IDLE; cfg_wr_valid_i outside LK_IDLE SHALL be ignored (table unchanged); in LK_IDLE a write wins over a simultaneous request.
REQ-020 In LK_MATCH, per entry i: hit_i = valid_i && qpn_i==qpn && vaddr>=vbase_i && (vaddr-vbase_i) < len_i, with 64-bit unsigned compares, len zero-extended to 64 bits; hit vector and offset registered; state -> LK_RESP.
REQ-021 Multiple hits SHALL resolve to the lowest index.
REQ-022 Hit response: paddr = pbase + offset (64-bit, wrap modulo 2^64), buflen = len - offset[47:0] (remaining bytes, always >=1), accesdesc = entry access.
REQ-023 Miss response: paddr=0, buflen=0, accesdesc=4'h0; miss_cnt_o increments once per missed lookup, saturating at 32'hFFFF_FFFF.
REQ-024 resp_addr_valid_o SHALL be 1 only in LK_RESP; resp_addr_data_o SHALL be stable while valid&&!ready; on ready, state -> LK_IDLE.
REQ-025 Latency: response valid exactly 2 cycles after the accepting edge; max throughput one lookup per 3 cycles.
REQ-026 resp_addr_data_o SHALL be driven from registers only.

Reset
REQ-027 rst_i asserted SHALL asynchronously force LK_IDLE, all entry valid bits 0, miss_cnt_o=0, resp_addr_valid_o=0, resp_addr_data_o=0; req_addr_ready_o=1 while no cfg write pending.
REQ-028 Reset mid-lookup SHALL drop the in-flight request with no response and no counter update.
REQ-029 Entry field contents other than valid need not be reset.

Verification
REQ-030 Write idx 3 {qpn=5, vbase=0x1000, pbase=0x8000_0000, len=0x100, access=4'h3}; lookup qpn 5 vaddr 0x1010 -> paddr 0x8000_0010, buflen 0xF0, accesdesc 3, valid 2 cycles after accept.
REQ-031 Same entry, lookup vaddr 0x1100 (end boundary) and qpn 6 vaddr 0x1010 -> both miss, paddr 0, buflen 0, miss_cnt_o=2.
REQ-032 Overlapping entries idx 1 and idx 7 both hitting -> idx 1 data returned.
REQ-033 resp_addr_ready_i held 0 for 5 cycles -> valid and data stable, req_addr_ready_o=0 throughout; next request accepted only after handshake.
REQ-034 cfg_wr_valid_i and req_addr_valid_i together in LK_IDLE -> write applied, request accepted next cycle and sees new entry; invalidate (entry_valid=0) then lookup -> miss.
REQ-035 Assert rst_i during LK_MATCH -> no response, all entries invalid, miss_cnt_o=0, subsequent lookup misses.
